alu_wide_sequencer: RTL

- Multi-cycle controller that runs NBYTES-wide operations on the shared 8-bit combinational ALU, one byte per cycle, LSB first.
- For ADD, the carry is chained between bytes with kAddC.
- Sits between the execute stage (request/response handshake) and the ALU instance. It owns the ALU's ctrl_input, a, b and cin while busy.

---
 rtl/alu_wide_sequencer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/alu_wide_sequencer.sv
// alu_wide_sequencer: drives the shared 8-bit ALU one byte per cycle, LSB first,
// to build NBYTES-wide ADD/AND/OR/NOT results for the execute stage.

package alu_wide_pkg;
  localparam logic [3:0] kAdd  = 4'd0;
  localparam logic [3:0] kAddC = 4'd1;
  localparam logic [3:0] kAnd  = 4'd2;
  localparam logic [3:0] kOr   = 4'd3;
  localparam logic [3:0] kNeg  = 4'd4;
endpackage

module alu_wide_sequencer
  import alu_wide_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [8*NBYTES-1:0]   req_a,
  input  logic [8*NBYTES-1:0]   req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [8*NBYTES-1:0]   rsp_data,
  output logic                  rsp_carry,
  output logic                  rsp_zero,
  output logic [3:0]            alu_ctrl,
  output logic [7:0]            alu_a,
  output logic [7:0]            alu_b,
  output logic                  alu_cin,
  input  logic [7:0]            alu_out,
  input  logic                  alu_cout,
  input  logic                  alu_zero
);

  localparam int IW = $clog2(NBYTES);
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_AND = 2'd1;
  localparam logic [1:0] OP_OR  = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [NBYTES-1:0][7:0]    a_q, a_d;
  logic [NBYTES-1:0][7:0]    b_q, b_d;
  logic [NBYTES-1:0][7:0]    res_q, res_d;
  logic [1:0]                op_q, op_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic                      carry_q, carry_d;
  logic                      zacc_q, zacc_d;

  // Handshake and response views come straight from the state and result registers.
  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_data  = res_q;
  assign rsp_carry = carry_q;
  assign rsp_zero  = zacc_q;

  // Next-state, per-byte capture and ALU drive; the ALU idles at kAdd 0+0 outside RUN.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    op_d     = op_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    zacc_d   = zacc_q;
    alu_ctrl = kAdd;
    alu_a    = 8'h00;
    alu_b    = 8'h00;
    alu_cin  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          a_d     = req_a;
          b_d     = req_b;
          op_d    = req_op;
          idx_d   = '0;
          carry_d = 1'b0;
          zacc_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        alu_a   = a_q[idx_q];
        alu_cin = carry_q;
        case (op_q)
          OP_ADD:  begin alu_ctrl = (idx_q == '0) ? kAdd : kAddC; alu_b = b_q[idx_q]; end
          OP_AND:  begin alu_ctrl = kAnd; alu_b = b_q[idx_q]; end
          OP_OR:   begin alu_ctrl = kOr;  alu_b = b_q[idx_q]; end
          default: begin alu_ctrl = kNeg; alu_b = 8'h00; end
        endcase
        res_d[idx_q] = alu_out;
        carry_d      = (op_q == OP_ADD) ? alu_cout : 1'b0;
        zacc_d       = zacc_q & alu_zero;
        // Index wraps to 0 on the last byte so it never exceeds NBYTES-1.
        if (idx_q == LAST) begin
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
        end
      end
      S_DONE: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      zacc_q  <= zacc_d;
    end
  end

endmodule
